// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS core: CPU phase codes and bus
// controller states.
package mips_pkg;

    typedef enum logic [2:0] {
        CPU_FETCH         = 3'd0,
        CPU_DECODE        = 3'd1,
        CPU_EXECUTE       = 3'd2,
        CPU_MEMORY_ACCESS = 3'd3,
        CPU_WRITE_BACK    = 3'd4
    } cpu_state_t;

    typedef enum logic [1:0] {
        BUS_IDLE = 2'd0,
        BUS_BUSY = 2'd1,
        BUS_DONE = 2'd2
    } bus_state_t;

    localparam logic [3:0] FETCH_BYTEEN = 4'b1111;

endpackage

// File: rtl/mips_bus_controller.sv
// Avalon-MM master for the multicycle MIPS core: instruction fetch and data
// load/store, with CPU stall generation and a waitrequest timeout.
//
//  state | meaning
//  IDLE  | no transfer; latch request fields when the CPU phase needs the bus
//  BUSY  | strobe asserted, fields held until waitrequest drops or timeout
//  DONE  | strobes low for one cycle; CPU phase advances here
module mips_bus_controller
    import mips_pkg::*;
#(
    parameter int unsigned TIMEOUT     = 256,
    parameter logic [31:0] RESET_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  cpu_state,
    input  logic [31:0] pc,
    input  logic [31:0] data_addr,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [31:0] data_wdata,
    input  logic [3:0]  data_byteen,
    output logic        stall,
    output logic [31:0] instr_reg,
    output logic [31:0] data_rdata,
    output logic        bus_err,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    output logic [3:0]  avm_byteenable,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    bus_state_t        state_q, state_d;
    logic              avm_read_q, avm_read_d;
    logic              avm_write_q, avm_write_d;
    logic [31:0]       avm_address_q, avm_address_d;
    logic [31:0]       avm_writedata_q, avm_writedata_d;
    logic [3:0]        avm_byteenable_q, avm_byteenable_d;
    logic              is_fetch_q, is_fetch_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0]       instr_reg_q, instr_reg_d;
    logic [31:0]       data_rdata_q, data_rdata_d;
    logic              bus_err_q, bus_err_d;

    logic is_fetch_phase;
    logic request;

    // Address bits [1:0] never reach the bus: transfers are word-aligned.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{pc[1:0], data_addr[1:0]};

    assign is_fetch_phase = (cpu_state == CPU_FETCH);
    assign request = is_fetch_phase |
                     ((cpu_state == CPU_MEMORY_ACCESS) & (data_read | data_write));
    assign stall   = request & (state_q != BUS_DONE);

    always_comb begin
        state_d          = state_q;
        avm_read_d       = avm_read_q;
        avm_write_d      = avm_write_q;
        avm_address_d    = avm_address_q;
        avm_writedata_d  = avm_writedata_q;
        avm_byteenable_d = avm_byteenable_q;
        is_fetch_d       = is_fetch_q;
        wait_cnt_d       = wait_cnt_q;
        instr_reg_d      = instr_reg_q;
        data_rdata_d     = data_rdata_q;
        bus_err_d        = bus_err_q;

        case (state_q)
            BUS_IDLE: begin
                if (request) begin
                    state_d    = BUS_BUSY;
                    wait_cnt_d = '0;
                    is_fetch_d = is_fetch_phase;
                    if (is_fetch_phase) begin
                        avm_address_d    = {pc[31:2], 2'b00};
                        avm_read_d       = 1'b1;
                        avm_write_d      = 1'b0;
                        avm_writedata_d  = '0;
                        avm_byteenable_d = FETCH_BYTEEN;
                    end else begin
                        avm_address_d    = {data_addr[31:2], 2'b00};
                        avm_byteenable_d = data_byteen;
                        // A store wins over a simultaneous load; the conflict is flagged.
                        if (data_write) begin
                            avm_read_d      = 1'b0;
                            avm_write_d     = 1'b1;
                            avm_writedata_d = data_wdata;
                            if (data_read) begin
                                bus_err_d = 1'b1;
                            end
                        end else begin
                            avm_read_d      = 1'b1;
                            avm_write_d     = 1'b0;
                            avm_writedata_d = '0;
                        end
                    end
                end
            end

            BUS_BUSY: begin
                if (!avm_waitrequest) begin
                    state_d     = BUS_DONE;
                    avm_read_d  = 1'b0;
                    avm_write_d = 1'b0;
                    if (avm_read_q) begin
                        if (is_fetch_q) begin
                            instr_reg_d = avm_readdata;
                        end else begin
                            data_rdata_d = avm_readdata;
                        end
                    end
                end else if (wait_cnt_q == CNT_LAST) begin
                    state_d     = BUS_DONE;
                    avm_read_d  = 1'b0;
                    avm_write_d = 1'b0;
                    bus_err_d   = 1'b1;
                    wait_cnt_d  = CNT_MAX;
                end else if (wait_cnt_q != CNT_MAX) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end

            BUS_DONE: begin
                state_d = BUS_IDLE;
            end

            default: begin
                state_d     = BUS_IDLE;
                avm_read_d  = 1'b0;
                avm_write_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= BUS_IDLE;
            avm_read_q       <= 1'b0;
            avm_write_q      <= 1'b0;
            avm_address_q    <= '0;
            avm_writedata_q  <= '0;
            avm_byteenable_q <= '0;
            is_fetch_q       <= 1'b0;
            wait_cnt_q       <= '0;
            instr_reg_q      <= RESET_INSTR;
            data_rdata_q     <= '0;
            bus_err_q        <= 1'b0;
        end else begin
            state_q          <= state_d;
            avm_read_q       <= avm_read_d;
            avm_write_q      <= avm_write_d;
            avm_address_q    <= avm_address_d;
            avm_writedata_q  <= avm_writedata_d;
            avm_byteenable_q <= avm_byteenable_d;
            is_fetch_q       <= is_fetch_d;
            wait_cnt_q       <= wait_cnt_d;
            instr_reg_q      <= instr_reg_d;
            data_rdata_q     <= data_rdata_d;
            bus_err_q        <= bus_err_d;
        end
    end

    assign avm_read       = avm_read_q;
    assign avm_write      = avm_write_q;
    assign avm_address    = avm_address_q;
    assign avm_writedata  = avm_writedata_q;
    assign avm_byteenable = avm_byteenable_q;
    assign instr_reg      = instr_reg_q;
    assign data_rdata     = data_rdata_q;
    assign bus_err        = bus_err_q;

endmodule

// File: tb/tb_mips_bus_controller.sv
// Self-checking bench for mips_bus_controller: directed and randomized bus
// transactions against a transaction-level reference model.
module tb_mips_bus_controller;

    localparam int unsigned TIMEOUT     = 8;
    localparam logic [31:0] RESET_INSTR = 32'h1234_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  cpu_state = 3'd1;
    logic [31:0] pc = '0;
    logic [31:0] data_addr = '0;
    logic        data_read = 1'b0;
    logic        data_write = 1'b0;
    logic [31:0] data_wdata = '0;
    logic [3:0]  data_byteen = '0;
    logic        stall;
    logic [31:0] instr_reg;
    logic [31:0] data_rdata;
    logic        bus_err;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic        avm_waitrequest = 1'b0;
    logic [31:0] avm_readdata = '0;

    int errors = 0;
    int checks = 0;

    // Reference model state: what the architectural registers should hold.
    logic [31:0] m_instr;
    logic [31:0] m_rdata;
    logic        m_err;

    mips_bus_controller #(
        .TIMEOUT    (TIMEOUT),
        .RESET_INSTR(RESET_INSTR)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cpu_state      (cpu_state),
        .pc             (pc),
        .data_addr      (data_addr),
        .data_read      (data_read),
        .data_write     (data_write),
        .data_wdata     (data_wdata),
        .data_byteen    (data_byteen),
        .stall          (stall),
        .instr_reg      (instr_reg),
        .data_rdata     (data_rdata),
        .bus_err        (bus_err),
        .avm_address    (avm_address),
        .avm_read       (avm_read),
        .avm_write      (avm_write),
        .avm_writedata  (avm_writedata),
        .avm_byteenable (avm_byteenable),
        .avm_waitrequest(avm_waitrequest),
        .avm_readdata   (avm_readdata)
    );

    always #5 clk = ~clk;

    // kind: 0 fetch, 1 load, 2 store, 3 load+store conflict
    task automatic access(input int kind, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input int waits, input logic [31:0] rd);
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        bit          is_wr;
        bit          tmo;
        int          exp_strobes;
        int          nstall;
        int          nstrobe;
        int          bad;
        bit          done;
        exp_addr    = {addr[31:2], 2'b00};
        exp_be      = (kind == 0) ? 4'b1111 : be;
        is_wr       = (kind >= 2);
        tmo         = (waits >= int'(TIMEOUT));
        exp_strobes = tmo ? int'(TIMEOUT) : waits + 1;
        nstall  = 0;
        nstrobe = 0;
        bad     = 0;
        done    = 1'b0;

        @(posedge clk); #1;
        avm_readdata = rd;
        if (kind == 0) begin
            cpu_state  = 3'd0;
            pc         = addr;
            data_addr  = $urandom;
            data_read  = 1'b0;
            data_write = 1'b0;
        end else begin
            cpu_state   = 3'd3;
            pc          = $urandom;
            data_addr   = addr;
            data_read   = (kind == 1) || (kind == 3);
            data_write  = (kind >= 2);
            data_wdata  = wdata;
            data_byteen = be;
        end

        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            if (stall !== 1'b1) begin
                done = 1'b1;
                if (avm_read !== 1'b0 || avm_write !== 1'b0) bad++;
            end else begin
                nstall++;
                if (avm_read === 1'b1 || avm_write === 1'b1) begin
                    nstrobe++;
                    if (avm_address !== exp_addr || avm_byteenable !== exp_be ||
                        avm_read !== !is_wr || avm_write !== is_wr ||
                        (is_wr && avm_writedata !== wdata)) bad++;
                    avm_waitrequest = (nstrobe <= waits);
                end
            end
        end

        checks++;
        if (!done) begin
            errors++;
            $display("FAIL stall_release kind=%0d: stall still high after 300 cycles, required release", kind);
        end
        checks++;
        if (nstall != exp_strobes + 1) begin
            errors++;
            $display("FAIL stall_cycles kind=%0d waits=%0d: got %0d required %0d", kind, waits, nstall, exp_strobes + 1);
        end
        checks++;
        if (nstrobe != exp_strobes) begin
            errors++;
            $display("FAIL strobe_cycles kind=%0d waits=%0d: got %0d required %0d", kind, waits, nstrobe, exp_strobes);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bus_fields kind=%0d: %0d cycles with wrong strobe/address/byteen/data, required 0", kind, bad);
        end

        if (!tmo && !is_wr) begin
            if (kind == 0) m_instr = rd;
            else           m_rdata = rd;
        end
        if (tmo || kind == 3) m_err = 1'b1;

        @(posedge clk); #1;
        cpu_state       = 3'd1;
        data_read       = 1'b0;
        data_write      = 1'b0;
        avm_waitrequest = 1'b0;
        @(negedge clk);
        checks++;
        if (instr_reg !== m_instr) begin
            errors++;
            $display("FAIL instr_reg kind=%0d: got %h required %h", kind, instr_reg, m_instr);
        end
        checks++;
        if (data_rdata !== m_rdata) begin
            errors++;
            $display("FAIL data_rdata kind=%0d: got %h required %h", kind, data_rdata, m_rdata);
        end
        checks++;
        if (bus_err !== m_err) begin
            errors++;
            $display("FAIL bus_err kind=%0d: got %b required %b", kind, bus_err, m_err);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        m_instr = RESET_INSTR;
        m_rdata = '0;
        m_err   = 1'b0;
        checks++;
        if (avm_read !== 1'b0 || avm_write !== 1'b0) begin
            errors++;
            $display("FAIL reset_strobes: got read=%b write=%b required 0 0", avm_read, avm_write);
        end
        checks++;
        if (avm_address !== 32'h0 || avm_writedata !== 32'h0 || avm_byteenable !== 4'h0) begin
            errors++;
            $display("FAIL reset_bus: got addr=%h wdata=%h be=%h required zeros", avm_address, avm_writedata, avm_byteenable);
        end
        checks++;
        if (instr_reg !== RESET_INSTR || data_rdata !== 32'h0 || bus_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_regs: got instr=%h rdata=%h err=%b required %h 0 0", instr_reg, data_rdata, bus_err, RESET_INSTR);
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_directed();
        access(0, 32'hBFC0_0000, 32'h0, 4'h0, 0, 32'h2402_0005);
        access(1, 32'h0000_1006, 32'h0, 4'b1111, 4, 32'hCAFE_F00D);
        access(2, 32'h0000_2001, 32'hDEAD_BEEF, 4'b0011, 0, 32'h5555_AAAA);
    endtask

    task automatic test_no_access();
        int bad;
        logic [2:0] phases [4];
        phases[0] = 3'd1; phases[1] = 3'd2; phases[2] = 3'd4; phases[3] = 3'd3;
        bad = 0;
        for (int p = 0; p < 4; p++) begin
            @(posedge clk); #1;
            cpu_state  = phases[p];
            pc         = $urandom;
            data_addr  = $urandom;
            data_read  = 1'b0;
            data_write = 1'b0;
            repeat (3) begin
                @(negedge clk);
                if (stall !== 1'b0 || avm_read !== 1'b0 || avm_write !== 1'b0) bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL no_access: %0d cycles with stall or strobe high, required 0", bad);
        end
        cpu_state = 3'd1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            access(int'($urandom_range(0, 2)), $urandom, $urandom, 4'($urandom),
                   int'($urandom_range(0, 5)), $urandom);
        end
    endtask

    task automatic test_conflict();
        access(3, 32'h0000_3008, 32'h0BAD_F00D, 4'b1100, 1, 32'h7777_7777);
    endtask

    task automatic test_timeout();
        access(0, 32'h0040_0010, 32'h0, 4'h0, 50, 32'hFFFF_0000);
        access(1, 32'h0000_4000, 32'h0, 4'b1111, int'(TIMEOUT) - 1, 32'h1357_9BDF);
    endtask

    task automatic test_reset_busy();
        int nstrobe;
        @(posedge clk); #1;
        cpu_state       = 3'd0;
        pc              = 32'h0000_8000;
        avm_readdata    = 32'hABCD_EF01;
        avm_waitrequest = 1'b1;
        nstrobe = 0;
        for (int c = 0; c < 20 && nstrobe < 3; c++) begin
            @(negedge clk);
            if (avm_read === 1'b1) nstrobe++;
        end
        checks++;
        if (nstrobe != 3) begin
            errors++;
            $display("FAIL reset_busy_start: got %0d strobe cycles required 3", nstrobe);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        m_instr = RESET_INSTR;
        m_rdata = '0;
        m_err   = 1'b0;
        checks++;
        if (avm_read !== 1'b0 || avm_write !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy_strobes: got read=%b write=%b required 0 0", avm_read, avm_write);
        end
        checks++;
        if (instr_reg !== RESET_INSTR || bus_err !== 1'b0 || data_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_busy_regs: got instr=%h err=%b rdata=%h required %h 0 0", instr_reg, bus_err, data_rdata, RESET_INSTR);
        end
        @(posedge clk); #1;
        reset           = 1'b0;
        cpu_state       = 3'd1;
        avm_waitrequest = 1'b0;
        access(0, 32'h0000_8004, 32'h0, 4'h0, 0, 32'h0000_0042);
    endtask

    initial begin
        m_instr = RESET_INSTR;
        m_rdata = '0;
        m_err   = 1'b0;
        test_reset();
        test_directed();
        test_no_access();
        test_random();
        test_conflict();
        test_timeout();
        test_reset_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
